// File: rtl/vp_pkg.sv
// Shared types for the load value predictor: FSM state, table entry, in-flight record.
// Latency: n/a (types and a helper only).
// Backpressure: n/a.
// Field widths of the structs are fixed here; the top-level width parameters must match them.
package vp_pkg;

   localparam int VP_DATA_WIDTH = 32;
   localparam int VP_TAG_BITS   = 8;
   localparam int VP_CONF_BITS  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SPEC    = 2'd1,
      RECOVER = 2'd2
   } vp_state_e;

   typedef struct packed {
      logic                     valid;
      logic [VP_TAG_BITS-1:0]   tag;
      logic [VP_DATA_WIDTH-1:0] value;
      logic [VP_CONF_BITS-1:0]  conf;
   } vp_entry_t;

   typedef struct packed {
      logic [VP_DATA_WIDTH-1:0] pc;
      logic [VP_DATA_WIDTH-1:0] value;
   } vp_inflight_t;

   // Saturating 32-bit event counter step.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/load_value_predictor_if.sv
// Pipeline <-> load value predictor bundle: lookup, prediction, resolve, recovery, status.
// Latency: prediction is combinational from lookup; recovery and status are registered.
// Backpressure: inflight_full and recover_req stall new predictions; no ready on resolve.
// Ports: master = pipeline/hazard side, slave = predictor.
interface load_value_predictor_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  lookup_valid;
   logic [DATA_WIDTH-1:0] lookup_pc;
   logic                  pred_valid;
   logic [DATA_WIDTH-1:0] pred_data;
   logic                  resolve_valid;
   logic [DATA_WIDTH-1:0] resolve_pc;
   logic [DATA_WIDTH-1:0] resolve_data;
   logic                  resolve_spec;
   logic                  flush;
   logic                  recover_req;
   logic [DATA_WIDTH-1:0] recover_pc;
   logic                  recover_ack;
   logic                  inflight_full;
   logic                  proto_err;
   logic [31:0]           n_predicts;
   logic [31:0]           n_mispredicts;

   modport master (
      output lookup_valid, lookup_pc, resolve_valid, resolve_pc, resolve_data,
             resolve_spec, flush, recover_ack,
      input  pred_valid, pred_data, recover_req, recover_pc, inflight_full,
             proto_err, n_predicts, n_mispredicts
   );

   modport slave (
      input  lookup_valid, lookup_pc, resolve_valid, resolve_pc, resolve_data,
             resolve_spec, flush, recover_ack,
      output pred_valid, pred_data, recover_req, recover_pc, inflight_full,
             proto_err, n_predicts, n_mispredicts
   );
endinterface

// File: rtl/vp_inflight_fifo.sv
// Circular FIFO of unverified predictions, oldest at head.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push ignored when full unless a pop happens in the same cycle; clear wins over push.
// Ports: clk, rst, push/push_dat, pop, clear, head, full, empty, count.
module vp_inflight_fifo
   import vp_pkg::*;
#(
   parameter type T     = vp_inflight_t,
   parameter int  DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  T                           push_dat,
   input  logic                       pop,
   input  logic                       clear,
   output T                           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   // A pop frees the head slot this edge, so a full FIFO can still accept the push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            cnt <= cnt + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value load predictor with confidence counters and an ordered in-flight verify queue.
// Latency: prediction combinational from lookup; training, verify and recovery take effect at the edge.
// Backpressure: no prediction while the in-flight queue is full, during RECOVER, or on flush.
// Ports: clk, rst (sync, active-high), bus (load_value_predictor_if.slave).
module load_value_predictor
   import vp_pkg::*;
#(
   parameter int DATA_WIDTH   = VP_DATA_WIDTH,  // must equal VP_DATA_WIDTH
   parameter int ENTRIES      = 16,
   parameter int TAG_BITS     = VP_TAG_BITS,    // must equal VP_TAG_BITS
   parameter int CONF_BITS    = VP_CONF_BITS,   // must equal VP_CONF_BITS
   parameter int CONF_THRESH  = 2,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   load_value_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
   localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);

   vp_entry_t    tbl [ENTRIES];
   vp_state_e    state;
   logic         recover_req;
   logic [DATA_WIDTH-1:0] recover_pc;
   logic         proto_err;
   logic [31:0]  n_predicts;
   logic [31:0]  n_mispredicts;

   // Lookup port
   logic [IDX_W-1:0]    lk_idx;
   logic [TAG_BITS-1:0] lk_tag;
   vp_entry_t           lk_ent;
   logic                lk_hit;
   logic                pred_valid;

   // Resolve port
   logic [IDX_W-1:0]    rs_idx;
   logic [TAG_BITS-1:0] rs_tag;
   vp_entry_t           rs_ent;
   logic                rs_hit;
   logic                rs_same;
   logic                train;
   logic                verify;
   logic                mismatch;

   // In-flight queue
   vp_inflight_t        push_dat;
   vp_inflight_t        head;
   logic                push;
   logic                pop;
   logic                clear;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_cnt;
   logic                spec_next;
   logic                unused_pc_bits;

   assign lk_idx = bus.lookup_pc[2 +: IDX_W];
   assign lk_tag = bus.lookup_pc[IDX_W + 2 +: TAG_BITS];
   assign lk_ent = tbl[lk_idx];
   assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

   assign pred_valid = bus.lookup_valid && lk_hit && (lk_ent.conf >= THRESH) &&
                       !fifo_full && (state != RECOVER) && !bus.flush;

   assign rs_idx  = bus.resolve_pc[2 +: IDX_W];
   assign rs_tag  = bus.resolve_pc[IDX_W + 2 +: TAG_BITS];
   assign rs_ent  = tbl[rs_idx];
   assign rs_hit  = rs_ent.valid && (rs_ent.tag == rs_tag);
   assign rs_same = (rs_ent.value == bus.resolve_data);

   // Resolves arriving while recovering belong to squashed work and are dropped entirely.
   assign train    = bus.resolve_valid && (state != RECOVER);
   assign verify   = train && bus.resolve_spec && !bus.flush;
   assign mismatch = verify && !fifo_empty && (head.value != bus.resolve_data);

   assign pop      = verify && !fifo_empty;
   // A mismatch squashes everything younger, including a prediction issued this cycle.
   assign push     = pred_valid && !mismatch;
   assign clear    = bus.flush || mismatch;
   assign push_dat = '{pc: bus.lookup_pc, value: lk_ent.value};

   // Occupancy after this edge is non-zero (clear handled separately).
   assign spec_next = push || (fifo_cnt > CNT_W'(1)) || ((fifo_cnt == CNT_W'(1)) && !pop);

   assign unused_pc_bits = ^{bus.lookup_pc, bus.resolve_pc};

   vp_inflight_fifo #(
      .T     (vp_inflight_t),
      .DEPTH (MAX_INFLIGHT)
   ) u_inflight_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .clear    (clear),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   // Prediction table: last value plus saturating confidence per entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= '0;
         end
      end else if (train) begin
         if (rs_hit && rs_same) begin
            if (rs_ent.conf != CONF_MAX) begin
               tbl[rs_idx].conf <= rs_ent.conf + 1'b1;
            end
         end else if (rs_hit) begin
            tbl[rs_idx].value <= bus.resolve_data;
            tbl[rs_idx].conf  <= '0;
         end else begin
            tbl[rs_idx] <= '{valid: 1'b1, tag: rs_tag, value: bus.resolve_data, conf: '0};
         end
      end
   end

   // Control FSM with registered recovery and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         recover_req   <= 1'b0;
         recover_pc    <= '0;
         proto_err     <= 1'b0;
         n_predicts    <= '0;
         n_mispredicts <= '0;
      end else begin
         if (pred_valid) begin
            n_predicts <= sat_inc32(n_predicts);
         end
         case (state)
            RECOVER: begin
               if (bus.recover_ack) begin
                  state       <= IDLE;
                  recover_req <= 1'b0;
               end
            end
            default: begin
               if (verify && fifo_empty) begin
                  proto_err <= 1'b1;
               end
               if (mismatch) begin
                  state         <= RECOVER;
                  recover_req   <= 1'b1;
                  recover_pc    <= head.pc;
                  n_mispredicts <= sat_inc32(n_mispredicts);
               end else if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  state <= spec_next ? SPEC : IDLE;
               end
            end
         endcase
      end
   end

   assign bus.pred_valid    = pred_valid;
   assign bus.pred_data     = lk_ent.value;
   assign bus.recover_req   = recover_req;
   assign bus.recover_pc    = recover_pc;
   assign bus.inflight_full = fifo_full;
   assign bus.proto_err     = proto_err;
   assign bus.n_predicts    = n_predicts;
   assign bus.n_mispredicts = n_mispredicts;

endmodule
